// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: merges the single-cycle ALU path with a
// queued long-latency LSU/MUL path and keeps the per-register busy scoreboard.
module rf_writeback_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_iss_valid,
    input  logic            i_iss_long,
    input  logic [4:0]      i_iss_rd,
    input  logic [4:0]      i_iss_rs1,
    input  logic [4:0]      i_iss_rs2,
    output logic            o_iss_hazard,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_lsu_ready,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_wren,
    output logic [XLEN-1:0] o_rd_data,
    output logic [31:0]     o_busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [31:0]     busy;
    logic [31:0]     busy_next;

    logic full;
    logic accept;
    logic alu_write;
    logic push;
    logic pop;
    logic set_busy;

    // A full queue refuses the ALU too, so the head is guaranteed to drain.
    assign full      = (count == FULL_COUNT);
    assign accept    = i_reset && !full;
    assign alu_write = i_alu_valid && accept && (i_alu_rd != 5'd0);
    assign push      = i_lsu_valid && accept && (i_lsu_rd != 5'd0);
    assign pop       = i_reset && !alu_write && (count != '0);
    assign set_busy  = i_iss_valid && i_iss_long && (i_iss_rd != 5'd0);

    assign o_alu_ready = accept;
    assign o_lsu_ready = accept;
    assign o_busy      = busy;

    assign o_iss_hazard = ((i_iss_rs1 != 5'd0) && busy[i_iss_rs1]) ||
                          ((i_iss_rs2 != 5'd0) && busy[i_iss_rs2]) ||
                          ((i_iss_rd  != 5'd0) && busy[i_iss_rd]);

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_rd[tail]   <= i_lsu_rd;
            q_data[tail] <= i_lsu_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[q_rd[head]] = 1'b0;
        end
        if (set_busy) begin
            busy_next[i_iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Address and data hold their last value on idle cycles; only wren drops.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (alu_write) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= i_alu_rd;
            o_rd_data <= i_alu_data;
        end else if (pop) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= q_rd[head];
            o_rd_data <= q_data[head];
        end else begin
            o_rd_wren <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            assert (!(i_iss_valid && o_iss_hazard))
                else $error("rf_writeback_ctrl: issue while hazard asserted");
            if (push) begin
                assert (busy[i_lsu_rd])
                    else $error("rf_writeback_ctrl: LSU result for non-busy x%0d", i_lsu_rd);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed and randomized checks of rf_writeback_ctrl against a queue-based
// reference model of the write-port arbitration and busy scoreboard.
module tb_rf_writeback_ctrl;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iss_valid, iss_long;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_hazard, alu_ready, lsu_ready, rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy;

    wr_t         mq[$];
    logic [31:0] mbusy = '0;
    logic        exp_wren = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset_n),
        .i_iss_valid(iss_valid), .i_iss_long(iss_long), .i_iss_rd(iss_rd),
        .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2), .o_iss_hazard(iss_hazard),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .o_alu_ready(alu_ready),
        .i_lsu_valid(lsu_valid), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
        .o_lsu_ready(lsu_ready),
        .o_rd_addr(rd_addr), .o_rd_wren(rd_wren), .o_rd_data(rd_data),
        .o_busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_fails++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            end
    endtask

    function automatic logic modelHazard(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return ((rs1 != 0) && mbusy[rs1]) || ((rs2 != 0) && mbusy[rs2]) || ((rd != 0) && mbusy[rd]);
    endfunction

    function automatic logic inQueue(input logic [4:0] r);
        foreach (mq[k]) if (mq[k].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic setIdle();
        reset_n = 1'b1;
        iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    // Checks the combinational outputs, advances one clock, updates the model
    // and checks the registered outputs and scoreboard.
    task automatic applyStimulus();
        logic ready;
        wr_t  hd;
        #2;
        ready = reset_n && (mq.size() != DEPTH);
        checkOutput("alu_ready", {31'b0, alu_ready}, {31'b0, ready});
        checkOutput("lsu_ready", {31'b0, lsu_ready}, {31'b0, ready});
        checkOutput("hazard", {31'b0, iss_hazard}, {31'b0, modelHazard(iss_rd, iss_rs1, iss_rs2)});
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            mbusy = '0;
            exp_wren = 1'b0; exp_addr = '0; exp_data = '0;
        end else begin
            if (alu_valid && ready && (alu_rd != 0)) begin
                exp_wren = 1'b1; exp_addr = alu_rd; exp_data = alu_data;
            end else if (mq.size() > 0) begin
                hd = mq.pop_front();
                exp_wren = 1'b1; exp_addr = hd.rd; exp_data = hd.data;
                mbusy[hd.rd] = 1'b0;
            end else begin
                exp_wren = 1'b0;
            end
            if (lsu_valid && ready && (lsu_rd != 0)) mq.push_back('{rd: lsu_rd, data: lsu_data});
            if (iss_valid && iss_long && (iss_rd != 0)) mbusy[iss_rd] = 1'b1;
        end
        #1;
        checkOutput("rd_wren", {31'b0, rd_wren}, {31'b0, exp_wren});
        checkOutput("rd_addr", {27'b0, rd_addr}, {27'b0, exp_addr});
        checkOutput("rd_data", rd_data, exp_data);
        checkOutput("busy", busy, mbusy);
    endtask

    task automatic issueLong(input logic [4:0] rd);
        setIdle();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = rd;
        applyStimulus();
    endtask

    initial begin
        logic [4:0] r;
        setIdle();
        reset_n = 1'b0;
        applyStimulus();
        applyStimulus();
        $display("[TB] reset done");

        // T1: single ALU write, visible for exactly one cycle
        setIdle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("t1_addr", {27'b0, rd_addr}, 32'd5);
        checkOutput("t1_data", rd_data, 32'hDEADBEEF);
        setIdle();
        applyStimulus();
        checkOutput("t1_wren_drop", {31'b0, rd_wren}, 32'd0);

        // T2: long op, hazard on dependent source, LSU completion
        issueLong(5'd7);
        checkOutput("t2_busy7", {31'b0, busy[7]}, 32'd1);
        setIdle();
        iss_rs1 = 5'd7; iss_rd = 5'd9;
        applyStimulus();
        setIdle();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("t2_addr", {27'b0, rd_addr}, 32'd7);
        checkOutput("t2_data", rd_data, 32'h1234);
        checkOutput("t2_busy7_clr", {31'b0, busy[7]}, 32'd0);

        // T3: ALU priority over queue head; ALU to x0 lets the head through
        issueLong(5'd3);
        issueLong(5'd6);
        setIdle();
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3333;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_0001;
        applyStimulus();
        lsu_valid = 1'b0; alu_data = 32'h4444_0002;
        applyStimulus();
        checkOutput("t3_alu2", {27'b0, rd_addr}, 32'd4);
        setIdle();
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h6666;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_0003;
        applyStimulus();
        checkOutput("t3_pop3_deferred", {27'b0, rd_addr}, 32'd4);
        setIdle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0_0000;
        applyStimulus();
        checkOutput("t3_pop3", {27'b0, rd_addr}, 32'd3);
        applyStimulus();
        checkOutput("t3_pop6", {27'b0, rd_addr}, 32'd6);

        // T4: fill queue under continuous ALU traffic, then drain in order
        for (int i = 8; i < 12; i++) issueLong(5'(i));
        for (int i = 8; i < 12; i++) begin
            setIdle();
            alu_valid = 1'b1; alu_rd = 5'd12; alu_data = $urandom;
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'hA000 + i;
            applyStimulus();
        end
        setIdle();
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = $urandom;
        applyStimulus();
        checkOutput("t4_head8", {27'b0, rd_addr}, 32'd8);
        for (int i = 9; i < 12; i++) begin
            setIdle();
            applyStimulus();
            checkOutput("t4_drain", {27'b0, rd_addr}, 32'(i));
        end

        // T5: x0 destinations on every path
        setIdle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h2;
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
        applyStimulus();
        checkOutput("t5_no_wren", {31'b0, rd_wren}, 32'd0);
        checkOutput("t5_busy0", busy, 32'd0);

        // T6: reset with queued writes and busy bits pending
        for (int i = 13; i < 16; i++) issueLong(5'(i));
        for (int i = 13; i < 16; i++) begin
            setIdle();
            alu_valid = 1'b1; alu_rd = 5'd20; alu_data = $urandom;
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = $urandom;
            applyStimulus();
        end
        reset_n = 1'b0;
        lsu_valid = 1'b0;
        applyStimulus();
        checkOutput("t6_busy_clr", busy, 32'd0);
        setIdle();
        applyStimulus();
        checkOutput("t6_no_write", {31'b0, rd_wren}, 32'd0);

        // Randomized traffic obeying the issue and LSU protocol rules
        for (int c = 0; c < 600; c++) begin
            setIdle();
            reset_n   = ($urandom_range(0, 80) != 0);
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            iss_rd    = 5'($urandom_range(0, 31));
            iss_rs1   = 5'($urandom_range(0, 31));
            iss_rs2   = 5'($urandom_range(0, 31));
            iss_long  = ($urandom_range(0, 1) != 0);
            iss_valid = ($urandom_range(0, 1) != 0) && !modelHazard(iss_rd, iss_rs1, iss_rs2);
            lsu_data  = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                lsu_valid = 1'b1;
                lsu_rd = 5'd0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    r = 5'($urandom_range(1, 31));
                    if (!lsu_valid && mbusy[r] && !inQueue(r)) begin
                        lsu_valid = 1'b1;
                        lsu_rd = r;
                    end
                end
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
